// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: operand width, opcode encodings
// and the arbiter FSM state type.
package alu_pkg;

    localparam int OPW = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU shared by all requesters of alu_arbiter.
// All results wrap modulo 2**OPW; NOT and shifts ignore operand b.
module alu
    import alu_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    input  logic [2:0]     op,
    output logic [OPW-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            OP_SHL:  y = {a[OPW-2:0], 1'b0};
            OP_SHR:  y = {1'b0, a[OPW-1:1]};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter feeding one shared ALU through an IDLE/EXEC/RESP FSM.
// Define ALU_ARBITER_ZERO_FLAG_EN to add the registered rsp_zero output.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [4*N_REQ-1:0]   req_a,
    input  logic [4*N_REQ-1:0]   req_b,
    input  logic [3*N_REQ-1:0]   req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [OPW-1:0]       rsp_data,
    output logic [IDW-1:0]       rsp_id
`ifdef ALU_ARBITER_ZERO_FLAG_EN
    ,
    output logic                 rsp_zero
`endif
);

    alu_state_e     state_q, state_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [OPW-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [IDW-1:0] last_q, last_d;
    logic [OPW-1:0] a_q, a_d;
    logic [OPW-1:0] b_q, b_d;
    logic [2:0]     op_q, op_d;

    logic           grant_vld;
    logic [IDW-1:0] grant_idx;
    logic [OPW-1:0] alu_y;
    int             idx;
    int             gsel;

    // Scan from farthest to nearest so the requester right after last_q wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_q) + k) % N_REQ;
            if (req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state_q == IDLE && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    alu u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        last_d      = last_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        gsel        = int'(grant_idx);
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    a_d      = req_a[OPW*gsel +: OPW];
                    b_d      = req_b[OPW*gsel +: OPW];
                    op_d     = req_op[3*gsel +: 3];
                    rsp_id_d = grant_idx;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_y;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    last_d      = rsp_id_q;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            last_q      <= IDW'(N_REQ - 1);
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            last_q      <= last_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

`ifdef ALU_ARBITER_ZERO_FLAG_EN
    logic zero_q, zero_d;

    always_comb begin
        zero_d = zero_q;
        if (state_q == EXEC) begin
            zero_d = (alu_y == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign rsp_zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: reset, all opcodes, wrap
// boundaries, round-robin order, response back-pressure and mid-flight reset.
module tb_alu_arbiter;

    localparam int N_REQ = 4;
    localparam int IDW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [4*N_REQ-1:0]   req_a;
    logic [4*N_REQ-1:0]   req_b;
    logic [3*N_REQ-1:0]   req_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [3:0]           rsp_data;
    logic [IDW-1:0]       rsp_id;
`ifdef ALU_ARBITER_ZERO_FLAG_EN
    logic                 rsp_zero;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef ALU_ARBITER_ZERO_FLAG_EN
        ,
        .rsp_zero  (rsp_zero)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int i, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op);
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
        req_op[3*i +: 3] = op;
    endtask

    // One isolated transaction on requester i, checked at every stage.
    task automatic single_op(input int i, input logic [3:0] a, input logic [3:0] b,
                             input logic [2:0] op, input logic [3:0] exp,
                             input logic zexp);
        @(negedge clk);
        req_valid    = '0;
        req_valid[i] = 1'b1;
        load(i, a, b, op);
        rsp_ready = 1'b1;
        #1;
        chk("accept_ready", 8'(req_ready), 8'(1 << i));
        @(negedge clk);
        req_valid = '0;
        chk("exec_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("exec_req_ready", 8'(req_ready), 8'd0);
        @(negedge clk);
        chk("rsp_valid", 8'(rsp_valid), 8'd1);
        chk("rsp_data", 8'(rsp_data), 8'(exp));
        chk("rsp_id", 8'(rsp_id), 8'(i));
`ifdef ALU_ARBITER_ZERO_FLAG_EN
        chk("rsp_zero", 8'(rsp_zero), 8'(zexp));
`else
        if (zexp === 1'bx) $display("[TB] note: unknown zero expectation");
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op_exp [8];
        op_exp = '{4'h8, 4'h2, 4'h1, 4'h7, 4'h6, 4'hA, 4'hA, 4'h2};

        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;

        // Reset held two cycles with every request asserted.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_ready", 8'(req_ready), 8'd0);
        chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("rst_rsp_data", 8'(rsp_data), 8'd0);
        chk("rst_rsp_id", 8'(rsp_id), 8'd0);
`ifdef ALU_ARBITER_ZERO_FLAG_EN
        chk("rst_rsp_zero", 8'(rsp_zero), 8'd0);
`endif
        rst       = 1'b0;
        req_valid = '0;

        // Every opcode on requester 0 with A=5, B=3.
        for (int o = 0; o < 8; o++) begin
            single_op(0, 4'h5, 4'h3, 3'(o), op_exp[o], 1'b0);
        end

        // Wrap-around boundaries on different requesters.
        single_op(1, 4'hF, 4'h1, 3'b000, 4'h0, 1'b1);
        single_op(2, 4'h3, 4'h5, 3'b001, 4'hE, 1'b0);
        single_op(3, 4'h8, 4'h0, 3'b110, 4'h0, 1'b1);

        // All requesters held valid: grants rotate 0,1,2,3,0.
        @(negedge clk);
        for (int i = 0; i < N_REQ; i++) load(i, 4'(i + 1), 4'h2, 3'b000);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            #1;
            chk("rr_grant", 8'(req_ready), 8'(1 << (t % 4)));
            @(negedge clk);
            chk("rr_exec_ready", 8'(req_ready), 8'd0);
            @(negedge clk);
            chk("rr_rsp_valid", 8'(rsp_valid), 8'd1);
            chk("rr_rsp_id", 8'(rsp_id), 8'(t % 4));
            chk("rr_rsp_data", 8'(rsp_data), 8'((t % 4) + 3));
            @(negedge clk);
        end

        // Back-pressure: requester 1 granted, rsp_ready low for 5 RESP cycles.
        #1;
        chk("bp_grant", 8'(req_ready), 8'h2);
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            chk("bp_rsp_valid", 8'(rsp_valid), 8'd1);
            chk("bp_rsp_data", 8'(rsp_data), 8'h4);
            chk("bp_rsp_id", 8'(rsp_id), 8'd1);
            chk("bp_req_ready", 8'(req_ready), 8'd0);
            if (s < 4) @(negedge clk);
        end
        rsp_ready = 1'b1;

        // Requester 2 accepted next, then reset lands in its EXEC cycle.
        @(negedge clk);
        #1;
        chk("pre_rst_grant", 8'(req_ready), 8'h4);
        @(negedge clk);
        chk("mid_exec_valid", 8'(rsp_valid), 8'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_req_ready", 8'(req_ready), 8'd0);
        chk("mid_rst_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("mid_rst_rsp_id", 8'(rsp_id), 8'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", 8'(req_ready), 8'h1);
        @(negedge clk);
        chk("post_rst_no_rsp", 8'(rsp_valid), 8'd0);
        @(negedge clk);
        chk("post_rst_rsp_valid", 8'(rsp_valid), 8'd1);
        chk("post_rst_rsp_id", 8'(rsp_id), 8'd0);
        chk("post_rst_rsp_data", 8'(rsp_data), 8'h3);
        req_valid = '0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
